// File: rtl/arbiter8way16.sv
// Round-robin arbiter sharing one 16-bit datapath among eight requesters.
// Optional burst-extend lock input is enabled by defining ARB_LOCK_EN.
module arbiter8way16 #(
    parameter int unsigned BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  req,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
`ifdef ARB_LOCK_EN
    input  logic        lock,
`endif
    output logic [7:0]  grant,
    output logic [2:0]  sel,
    output logic [15:0] out,
    output logic        outValid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  grant_q, grant_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [3:0]  count_q, count_d;

    logic        win_found;
    logic [2:0]  win_idx;
    logic        hold_req;
    logic        at_limit;
    logic        lock_hold;
    logic        release_now;

    // First set request bit at or above ptr, wrapping 7 -> 0.
    always_comb begin
        logic [2:0] idx;
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign hold_req = req[sel_q];
    assign at_limit = (count_q == 4'(BURST));
`ifdef ARB_LOCK_EN
    assign lock_hold = lock && hold_req;
`else
    assign lock_hold = 1'b0;
`endif
    assign release_now = !hold_req || (at_limit && !lock_hold);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    grant_d = 8'b1 << win_idx;
                    sel_d   = win_idx;
                    count_d = 4'd1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = 8'h00;
                    ptr_d   = sel_q + 3'd1;
                end else begin
                    // Saturates at the limit while a lock holds the grant.
                    count_d = at_limit ? count_q : count_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 8'h00;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        unique case (sel_q)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            3'd7:    out = h;
            default: out = a;
        endcase
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign outValid = |grant_q;

endmodule

// File: tb/tb_arbiter8way16.sv
// Directed bench for arbiter8way16 with BURST=4 and BURST=1 instances,
// plus a BURST=2 instance exercising the lock input when ARB_LOCK_EN is set.
module tb_arbiter8way16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  req;
    logic [15:0] da, db, dc, dd, de, df, dg, dh;
    logic        lock;

    logic [7:0]  grant4, grant1;
    logic [2:0]  sel4, sel1;
    logic [15:0] out4, out1;
    logic        ov4, ov1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    arbiter8way16 #(.BURST(4)) u_b4 (
        .clock(clk), .reset(reset), .req(req),
        .a(da), .b(db), .c(dc), .d(dd),
        .e(de), .f(df), .g(dg), .h(dh),
`ifdef ARB_LOCK_EN
        .lock(1'b0),
`endif
        .grant(grant4), .sel(sel4), .out(out4), .outValid(ov4)
    );

    arbiter8way16 #(.BURST(1)) u_b1 (
        .clock(clk), .reset(reset), .req(req),
        .a(da), .b(db), .c(dc), .d(dd),
        .e(de), .f(df), .g(dg), .h(dh),
`ifdef ARB_LOCK_EN
        .lock(1'b0),
`endif
        .grant(grant1), .sel(sel1), .out(out1), .outValid(ov1)
    );

`ifdef ARB_LOCK_EN
    logic [7:0]  grant2;
    logic [2:0]  sel2;
    logic [15:0] out2;
    logic        ov2;

    arbiter8way16 #(.BURST(2)) u_b2 (
        .clock(clk), .reset(reset), .req(req),
        .a(da), .b(db), .c(dc), .d(dd),
        .e(de), .f(df), .g(dg), .h(dh),
        .lock(lock),
        .grant(grant2), .sel(sel2), .out(out2), .outValid(ov2)
    );
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        lock  = 1'b0;
        da = 16'h0; db = 16'h1; dc = 16'h2; dd = 16'h3;
        de = 16'h4; df = 16'h5; dg = 16'h6; dh = 16'h7;

        // Reset and idle
        step();
        chk("rst_grant", 16'(grant4), 16'h00);
        chk("rst_sel", 16'(sel4), 16'h0);
        chk("rst_valid", 16'(ov4), 16'h0);
        chk("rst_out", out4, 16'h0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_grant", 16'(grant4), 16'h00);
            chk("idle_out", out4, 16'h0);
        end

        // Single requester, BURST=4
        req = 8'h04;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("single_grant", 16'(grant4), 16'h04);
            chk("single_sel", 16'(sel4), 16'h2);
            chk("single_out", out4, 16'h2);
            chk("single_valid", 16'(ov4), 16'h1);
        end
        step();
        chk("single_gap", 16'(grant4), 16'h00);
        chk("single_gap_sel", 16'(sel4), 16'h2);
        step();
        chk("single_regrant", 16'(grant4), 16'h04);

        // Round robin, BURST=1
        req   = 8'h00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_grant", 16'(grant1), 16'(8'b1 << i));
            chk("rr_out", out1, 16'(i));
            step();
            chk("rr_gap", 16'(grant1), 16'h00);
        end
        step();
        chk("rr_wrap", 16'(grant1), 16'h01);

        // Early release and ptr wrap on BURST=4
        req   = 8'h00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 8'h40;
        step();
        chk("pre_grant6", 16'(grant4), 16'h40);
        req = 8'h00;
        step();
        chk("pre_rel6", 16'(grant4), 16'h00);
        req = 8'h81;
        step();
        chk("wrap_grant7a", 16'(grant4), 16'h80);
        chk("wrap_out7", out4, 16'h7);
        step();
        chk("wrap_grant7b", 16'(grant4), 16'h80);
        req = 8'h01;
        step();
        chk("early_rel", 16'(grant4), 16'h00);
        chk("early_rel_sel", 16'(sel4), 16'h7);
        step();
        chk("wrap_grant0", 16'(grant4), 16'h01);
        chk("wrap_out0", out4, 16'h0);

        // Reset mid-grant
        req = 8'h00;
        step();
        chk("mid_rel", 16'(grant4), 16'h00);
        req = 8'h10;
        step();
        chk("mid_grant4", 16'(grant4), 16'h10);
        chk("mid_sel4", 16'(sel4), 16'h4);
        reset = 1'b1;
        req   = 8'h11;
        step();
        chk("mid_rst_grant", 16'(grant4), 16'h00);
        chk("mid_rst_sel", 16'(sel4), 16'h0);
        reset = 1'b0;
        step();
        chk("mid_post_grant", 16'(grant4), 16'h01);

`ifdef ARB_LOCK_EN
        // Lock holds index 0 past BURST=2
        req   = 8'h00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 8'h03;
        lock  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("lock_hold", 16'(grant2), 16'h01);
        end
        req = 8'h02;
        step();
        chk("lock_rel", 16'(grant2), 16'h00);
        step();
        chk("lock_next", 16'(grant2), 16'h02);
        chk("lock_next_out", out2, 16'h1);
        lock = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
